sseg_scan_scheduler: RTL
========================

Name: sseg_scan_scheduler

Overview:
Time-multiplexes the single shared registered seven_seg_decoder across NUM_DIGITS common-anode digits. Each refresh slot the block drives one BCD digit onto the decoder input and enables exactly one active-low anode. A blanking window at the start of every slot absorbs the decoder's 1-cycle latency and prevents ghosting. New display words arrive through a load/ack handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 is least significant.
REFRESH_DIV, 100000, clk cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be at least 2.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
enable_i  in  1  scan enable; low forces the display dark.
digits_i  in  4*NUM_DIGITS  display word; digit k occupies bits [4k+3:4k].
load_i  in  1  one-cycle request to load digits_i.
lz_en_i  in  1  leading-zero suppression enable.
load_ack_o  out  1  one-cycle pulse when a loaded word is committed to the active register.
bcd_seg_o  out  4  digit to the shared decoder; 4'hF means blank (decoder default case).
an_o  out  NUM_DIGITS  anode enables, active-low.
digit_idx_o  out  clog2(NUM_DIGITS)  index of the current slot.
frame_done_o  out  1  one-cycle pulse at the end of the last slot of each frame.

Behaviour:
- All outputs are registered. reset is sampled only on the clk rising edge.
- Reset values:
  - an_o all 1s; bcd_seg_o 4'hF; digit_idx_o 0.
  - load_ack_o 0; frame_done_o 0.
  - slot counter 0; state IDLE.
  - active register all 4'hF; shadow register don't-care; pending flag 0.
- FSM states:
  - IDLE: an_o all 1s, bcd_seg_o 4'hF, counters held at 0.
  - BLANK: slot_cnt in 0..BLANK_CYCLES-1; an_o all 1s.
  - SHOW: slot_cnt in BLANK_CYCLES..REFRESH_DIV-1; an_o has only bit digit_idx_o low.
- Transitions:
  - IDLE -> BLANK when enable_i=1; entry is at idx 0, slot_cnt 0.
  - BLANK -> SHOW when slot_cnt reaches BLANK_CYCLES.
  - SHOW -> BLANK when slot_cnt = REFRESH_DIV-1. On that edge slot_cnt wraps to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
  - Any state -> IDLE on the edge after enable_i is sampled 0. That edge also sets an_o all 1s, bcd_seg_o 4'hF, idx 0, slot_cnt 0.
- bcd_seg_o updates on the edge that enters slot_cnt=0 of slot k:
  - value is active digit k, or 4'hF if that digit is suppressed;
  - it is stable for the whole slot;
  - the decoder output settles one cycle later, still inside BLANK.
- Leading-zero suppression (lz_en_i=1):
  - digit k is suppressed when it and every more-significant digit equal 0;
  - digit 0 is never suppressed;
  - digits > 9 pass through unchanged; the decoder blanks them.
- Load handshake:
  - load_i=1 captures digits_i into the shadow register and sets pending.
  - A second load before commit overwrites the shadow; latest wins, and only one ack is issued.
- Commit point: the final cycle of slot NUM_DIGITS-1 (SHOW, slot_cnt=REFRESH_DIV-1, idx=NUM_DIGITS-1). On that edge:
  - frame_done_o pulses;
  - if pending, active <= shadow, pending clears, load_ack_o pulses;
  - if load_i=1 in that same cycle, active <= digits_i directly (bypass) and load_ack_o pulses.
- In IDLE, a pending or current load commits on the next edge with a load_ack_o pulse.
- frame_done_o never pulses in IDLE.
- Reset mid-operation drops any pending load without an ack and blanks the active register.
- Width rules:
  - slot counter width is clog2(REFRESH_DIV);
  - no arithmetic on digit values;
  - idx wrap uses explicit compare, not power-of-two overflow.

Test Plan:
1. Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
   - Reset held 3 cycles with enable_i=1 -> an_o=4'b1111, bcd_seg_o=4'hF, no pulses. After release: idx 0, BLANK for 2 cycles, then an_o=4'b1110 for 6 cycles.
2. load_i with digits_i=16'h1234, lz_en_i=0 -> load_ack_o pulses exactly at the next frame's last cycle, together with frame_done_o. Following frame: bcd_seg_o = 4,3,2,1 in 8-cycle slots; an_o = 1110, 1101, 1011, 0111 in cycles 2-7 of each slot; frame_done_o every 32 cycles.
3. lz_en_i=1, load 16'h0070 -> bcd_seg_o = 0, 7, F, F for idx 0..3. Load 16'h0000 -> bcd_seg_o = 0, F, F, F.
4. Repeated loads:
   - 16'h1111 at frame cycle 5, then 16'h2222 at cycle 10 -> single load_ack_o at the boundary, next frame shows 2s.
   - load_i in the commit cycle -> committed on that edge with the ack.
5. enable_i dropped at slot 2, cycle 4, with a load pending -> next cycle an_o=4'b1111, bcd_seg_o=F, idx 0; ack on the following edge. Re-enable -> restarts at idx 0, slot_cnt 0, in BLANK.
6. reset asserted mid-SHOW with a load pending -> an_o=4'b1111 next edge, no load_ack_o. After release: all digits show F until a new load is committed.

Source files
------------

// File: rtl/sseg_scan_scheduler.sv
// Seven-segment scan scheduler: time-multiplexes one shared registered
// BCD-to-segment decoder across NUM_DIGITS common-anode digits. Each slot
// opens with a blanking window (all anodes off) that covers the decoder's
// one-cycle latency. New display words are double-buffered and only swapped
// in at frame boundaries, so a frame never mixes old and new digits.
module sseg_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  input  logic                    lz_en_i,
  output logic                    load_ack_o,
  output logic [3:0]              bcd_seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [IDX_W-1:0]        digit_idx_o,
  output logic                    frame_done_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]        BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK  = {NUM_DIGITS{4'hF}};

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        slot_cnt_reg, slot_cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] active_reg, active_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg, shadow_next;
  logic                    pending_reg, pending_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [3:0]              bcd_reg, bcd_next;
  logic                    ack_reg, ack_next;
  logic                    frame_done_reg, frame_done_next;

  logic                    frame_end;
  logic                    commit_pt;
  logic                    slot_entry;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              disp_digit [NUM_DIGITS];

  // Last cycle of the last slot while scanning is the only running commit
  // point; in IDLE nothing is on screen so a word can commit immediately.
  assign frame_end = (state_reg == ST_SHOW) && (slot_cnt_reg == CNT_LAST) &&
                     (idx_reg == IDX_LAST) && enable_i;
  assign commit_pt = frame_end || (state_reg == ST_IDLE);

  // Load handshake: a load in the commit cycle bypasses the shadow so the
  // newest word always wins and only one ack is produced per commit.
  always_comb begin
    active_next  = active_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    ack_next     = 1'b0;
    if (commit_pt && load_i) begin
      active_next  = digits_i;
      pending_next = 1'b0;
      ack_next     = 1'b1;
    end else if (commit_pt && pending_reg) begin
      active_next  = shadow_reg;
      pending_next = 1'b0;
      ack_next     = 1'b1;
    end else if (load_i) begin
      shadow_next  = digits_i;
      pending_next = 1'b1;
    end
  end

  // Leading-zero mask, built from the word that will be active after this
  // edge so the first slot of a new frame already shows the new word.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    suppress = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (active_next[4*k +: 4] == 4'h0);
      suppress[k] = lz_en_i && zero_run && (k != 0);
    end
  end

  // Per-digit display value; codes above 9 pass through for the decoder.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
    assign disp_digit[gi] = suppress[gi] ? 4'hF : active_next[4*gi +: 4];
  end

  // Scan FSM: slot counter, digit index, anode and decoder-input updates.
  always_comb begin
    state_next    = state_reg;
    slot_cnt_next = slot_cnt_reg;
    idx_next      = idx_reg;
    an_next       = an_reg;
    bcd_next      = bcd_reg;
    slot_entry    = 1'b0;
    if (!enable_i) begin
      state_next    = ST_IDLE;
      slot_cnt_next = '0;
      idx_next      = '0;
      an_next       = '1;
      bcd_next      = 4'hF;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next    = ST_BLANK;
          slot_cnt_next = '0;
          idx_next      = '0;
          an_next       = '1;
          slot_entry    = 1'b1;
        end
        ST_BLANK: begin
          slot_cnt_next = slot_cnt_reg + 1'b1;
          if (slot_cnt_reg == BLANK_LAST) begin
            state_next       = ST_SHOW;
            an_next          = '1;
            an_next[idx_reg] = 1'b0;
          end
        end
        ST_SHOW: begin
          if (slot_cnt_reg == CNT_LAST) begin
            state_next    = ST_BLANK;
            slot_cnt_next = '0;
            idx_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            an_next       = '1;
            slot_entry    = 1'b1;
          end else begin
            slot_cnt_next = slot_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          slot_cnt_next = '0;
          idx_next      = '0;
          an_next       = '1;
          bcd_next      = 4'hF;
        end
      endcase
    end
    if (slot_entry) begin
      bcd_next = disp_digit[idx_next];
    end
  end

  assign frame_done_next = frame_end;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      slot_cnt_reg   <= '0;
      idx_reg        <= '0;
      active_reg     <= ALL_BLANK;
      pending_reg    <= 1'b0;
      an_reg         <= '1;
      bcd_reg        <= 4'hF;
      ack_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_cnt_reg   <= slot_cnt_next;
      idx_reg        <= idx_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      an_reg         <= an_next;
      bcd_reg        <= bcd_next;
      ack_reg        <= ack_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Shadow word needs no reset: it is only read while pending is set.
  always_ff @(posedge clk) begin
    shadow_reg <= shadow_next;
  end

  assign load_ack_o   = ack_reg;
  assign bcd_seg_o    = bcd_reg;
  assign an_o         = an_reg;
  assign digit_idx_o  = idx_reg;
  assign frame_done_o = frame_done_reg;

endmodule
